// File: rtl/aes_pkg.sv
// Shared constants, Rcon table, S-box function and FSM states for the AES-256 key schedule.
package aes_pkg;

  localparam int unsigned NK     = 8;
  localparam int unsigned NR     = 14;
  localparam int unsigned NW     = 60;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned RND_W  = 4;

  // Round constants indexed by idx/8; entry 0 is never used.
  localparam logic [7:0] RCON [0:7] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                        8'h08, 8'h10, 8'h20, 8'h40};

  // Exponent 254 gives the multiplicative inverse in GF(2^8) (0 maps to 0).
  localparam logic [7:0] INV_EXP = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_SERVE  = 2'd2
  } state_e;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box: GF inverse followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (INV_EXP[i]) r = gf_mul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/subword32.sv
// Four parallel S-box lookups on a 32-bit word, purely combinational.
module subword32
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_sub_c
);

  // Substitute each byte independently.
  always_comb begin
    o_sub_c = '0;
    for (int b = 0; b < 4; b++) begin
      o_sub_c[8*b +: 8] = sbox(i_word[8*b +: 8]);
    end
  end

endmodule

// File: rtl/dec_keysched256.sv
// AES-256 key expansion (one word per cycle) that serves round keys 14..0
// to a decryption datapath over a valid/ready handshake, with replay.
module dec_keysched256
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic         replay,
  output logic         busy,
  output logic         keys_loaded,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk,
  output logic         rk_last
);

  state_e             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [RND_W-1:0]   r_rnd;
  logic               r_busy;
  logic               r_keys_loaded;
  logic               r_rk_valid;
  logic               r_rk_last;
  logic [127:0]       r_rk;
  logic [WORD_W-1:0]  r_store [NW];

  state_e             w_state_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [RND_W-1:0]   w_rnd_nxt;
  logic               w_loaded_nxt;
  logic               w_valid_nxt;
  logic               w_last_nxt;
  logic               w_busy_nxt;
  logic [127:0]       w_rk_nxt;
  logic               w_load_key;
  logic               w_word_we;

  logic [WORD_W-1:0]  w_prev;
  logic [WORD_W-1:0]  w_back;
  logic [WORD_W-1:0]  w_sub_in;
  logic [WORD_W-1:0]  w_sub;
  logic [WORD_W-1:0]  w_t;
  logic [WORD_W-1:0]  w_new;
  logic [RND_W-1:0]   w_rnd_dec;
  logic [127:0]       w_dec_key;
  logic [127:0]       w_top_key;
  logic [127:0]       w_fin_key;

  assign busy        = r_busy;
  assign keys_loaded = r_keys_loaded;
  assign rk_valid    = r_rk_valid;
  assign rk_last     = r_rk_last;
  assign rk_round    = r_rnd;
  assign rk          = r_rk;

  // Expansion datapath: w[idx] = w[idx-8] ^ t.
  assign w_prev   = r_store[r_idx - 6'd1];
  assign w_back   = r_store[r_idx - 6'd8];
  assign w_sub_in = (r_idx[2:0] == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  subword32 u_subword32 (
    .i_word  (w_sub_in),
    .o_sub_c (w_sub)
  );

  // Select the temp word according to the position within the 8-word group.
  always_comb begin
    w_t = w_prev;
    case (r_idx[2:0])
      3'd0:    w_t = w_sub ^ {RCON[r_idx[5:3]], 24'h000000};
      3'd4:    w_t = w_sub;
      default: w_t = w_prev;
    endcase
  end

  assign w_new = w_back ^ w_t;

  // Round-key reads: next lower round, top round, and top round while w59 is written.
  assign w_rnd_dec = r_rnd - 4'd1;
  assign w_dec_key = {r_store[{w_rnd_dec, 2'b00}], r_store[{w_rnd_dec, 2'b01}],
                      r_store[{w_rnd_dec, 2'b10}], r_store[{w_rnd_dec, 2'b11}]};
  assign w_top_key = {r_store[56], r_store[57], r_store[58], r_store[59]};
  assign w_fin_key = {r_store[56], r_store[57], r_store[58], w_new};

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_rnd_nxt    = r_rnd;
    w_loaded_nxt = r_keys_loaded;
    w_valid_nxt  = r_rk_valid;
    w_rk_nxt     = r_rk;
    w_load_key   = 1'b0;
    w_word_we    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load_key   = 1'b1;
          w_loaded_nxt = 1'b0;
          w_idx_nxt    = IDX_W'(NK);
          w_state_nxt  = ST_EXPAND;
        end else if (replay && r_keys_loaded) begin
          w_rnd_nxt   = RND_W'(NR);
          w_valid_nxt = 1'b1;
          w_rk_nxt    = w_top_key;
          w_state_nxt = ST_SERVE;
        end
      end
      ST_EXPAND: begin
        w_word_we = 1'b1;
        w_idx_nxt = r_idx + 6'd1;
        if (r_idx == IDX_W'(NW - 1)) begin
          w_loaded_nxt = 1'b1;
          w_rnd_nxt    = RND_W'(NR);
          w_valid_nxt  = 1'b1;
          w_rk_nxt     = w_fin_key;
          w_state_nxt  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (start) begin
          w_load_key   = 1'b1;
          w_loaded_nxt = 1'b0;
          w_idx_nxt    = IDX_W'(NK);
          w_valid_nxt  = 1'b0;
          w_state_nxt  = ST_EXPAND;
        end else if (r_rk_valid && rk_ready) begin
          if (r_rnd == 4'd0) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_rnd_nxt = w_rnd_dec;
            w_rk_nxt  = w_dec_key;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_EXPAND);
    w_last_nxt = w_valid_nxt && (w_rnd_nxt == 4'd0);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_rnd         <= '0;
      r_busy        <= 1'b0;
      r_keys_loaded <= 1'b0;
      r_rk_valid    <= 1'b0;
      r_rk_last     <= 1'b0;
      r_rk          <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_rnd         <= w_rnd_nxt;
      r_busy        <= w_busy_nxt;
      r_keys_loaded <= w_loaded_nxt;
      r_rk_valid    <= w_valid_nxt;
      r_rk_last     <= w_last_nxt;
      r_rk          <= w_rk_nxt;
    end
  end

  // Schedule word store; contents are only trusted while keys_loaded is set.
  always_ff @(posedge clk) begin
    if (w_load_key) begin
      for (int i = 0; i < NK; i++) begin
        r_store[i] <= key[32*(NK-1-i) +: 32];
      end
    end else if (w_word_we) begin
      r_store[r_idx] <= w_new;
    end
  end

endmodule
